sram_uart_dump: RTL and testbench
=================================

Name: sram_uart_dump

Overview:
- Read-back/transmit half of the UART–SRAM link: reads a block of 16-bit SRAM words and serialises them as 8N1 UART bytes on UART_TX.
- Low byte is sent first, then high byte.
- Sits beside the SRAM controller on the same sysclk; it receives the 16x baud tick from the existing baud generator.
- Lets a host dump SRAM contents written earlier through the receiver path.

Parameters:
- ADDR_W, 19, SRAM word-address width.
- READ_LAT, 2, sysclk cycles from sram_rd_en/sram_addr valid to sram_rdata valid; legal range 1..7.
- OVERSAMPLE, 16, baud ticks per UART bit.

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- brclk16_tick  in  1  one-sysclk-wide pulse at 16x baud rate.
- start  in  1  single-cycle request to begin a dump; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; latched on accepted start.
- word_count  in  ADDR_W  number of words to send; latched on accepted start.
- sram_rdata  in  16  read data from the SRAM controller.
- sram_addr_r  out  ADDR_W  read address driven to the SRAM controller.
- sram_rd_en  out  1  read strobe, high for exactly 1 cycle per word.
- UART_TX  out  1  serial output; idles high.
- busy  out  1  high from accepted start until done.
- done  out  1  1-cycle pulse when the last byte's stop bit completes.

Behaviour:
- Reset (reset==0 at a clock edge) overrides everything, including mid-frame:
  - UART_TX=1, busy=0, done=0, sram_rd_en=0, sram_addr_r=0.
  - FSM returns to IDLE; all counters are cleared.
- FSM states: IDLE, RD, WAIT, TX_LO, TX_HI, NEXT, FIN.
- IDLE:
  - start=1 with word_count!=0: latch addr and count, busy=1, go to RD.
  - start=1 with word_count==0: go to FIN, so done pulses the next cycle and no byte is sent.
- RD: sram_addr_r=addr, sram_rd_en=1 for one cycle, go to WAIT.
- WAIT: count READ_LAT cycles. On the final cycle, capture sram_rdata into a 16-bit holding register, then go to TX_LO.
- TX_LO: load rdata[7:0] into the serializer and wait for its tx_done, then go to TX_HI.
- TX_HI: same for rdata[15:8], then go to NEXT.
- NEXT:
  - count = count-1 and addr = addr+1, modulo 2^ADDR_W (0x7FFFF wraps to 0x00000).
  - Go to RD if the new count !=0, else to FIN.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- start asserted while busy is ignored; the latched parameters do not change.
- Serializer frame:
  - Start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit is held for exactly OVERSAMPLE brclk16_tick pulses.
  - A bit boundary occurs only on a tick; a load waits for the next tick to begin the start bit.
  - tx_done pulses 1 cycle after the 16th tick of the stop bit.
- Inter-byte gap is implementation-defined but ≤ 1 bit time. Between words it is also bounded by READ_LAT+3 sysclk cycles.
- The block never samples sram_rdata outside the WAIT capture cycle.

Optional Feature:
- Macro: SRAM_UART_DUMP_CHECKSUM_EN.
- When defined:
  - An 8-bit XOR accumulator over every transmitted data byte clears on accepted start.
  - After the last word, state TX_CK sends the accumulator as one extra frame before FIN.
  - A word_count==0 dump sends a single 0x00 checksum byte.
- When undefined: no accumulator, no TX_CK, and frame count is exactly 2×word_count.

Decomposition:
- Shared package sram_uart_pkg holds:
  - the FSM state enum;
  - UART frame constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8);
  - the default ADDR_W.
- One sub-module, uart_transmitter. It contains the byte serializer with ports sysclk, reset, brclk16_tick, tx_load, tx_byte[7:0], UART_TX, tx_busy and tx_done.
- The FSM and address/count logic stay in the top module.

Test Plan:
- Single word: base_addr=0x00010, word_count=1, SRAM[0x10]=0xA55A.
  - Required: UART_TX decodes bytes 0x5A then 0xA5; sram_rd_en pulses once with sram_addr_r=0x00010.
  - Required: done pulses once and busy falls with it; each bit lasts 16 ticks.
- Zero count: word_count=0.
  - Required: no frame, UART_TX stays 1; done pulses within 2 cycles of start; with CHECKSUM_EN, one 0x00 frame is sent first.
- Wrap: base_addr=0x7FFFF, word_count=2, SRAM[0x7FFFF]=0x1234, SRAM[0]=0xBEEF.
  - Required: reads hit 0x7FFFF then 0x00000; bytes are 0x34,0x12,0xEF,0xBE.
  - Required with CHECKSUM_EN: trailing byte 0x34^0x12^0xEF^0xBE=0x77.
- Mid-frame reset: assert reset=0 during the 4th data bit of byte 1.
  - Required: UART_TX=1, busy=0, sram_rd_en=0 on the next edge; no done pulse.
  - Required: a subsequent start with word_count=1 produces a clean frame.
- Start while busy: second start with different base_addr during a 3-word dump.
  - Required: ignored; exactly 6 bytes from the original base are sent and done pulses once.
- READ_LAT=3 with SRAM data changing 1 cycle after capture.
  - Required: the transmitted bytes equal the data valid exactly 3 cycles after sram_rd_en.

Source files
------------

// File: rtl/sram_uart_pkg.sv
// Shared definitions for the SRAM-to-UART dump path: FSM states and 8N1 frame constants.
// The TX_CK state only exists when SRAM_UART_DUMP_CHECKSUM_EN is defined.
package sram_uart_pkg;

    localparam int DEF_ADDR_W = 19;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        WAIT  = 3'd2,
        TX_LO = 3'd3,
        TX_HI = 3'd4,
        NEXT  = 3'd5,
        FIN   = 3'd6
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
        ,
        TX_CK = 3'd7
`endif
    } state_e;

endpackage

// File: rtl/uart_transmitter.sv
// 8N1 byte serializer driven by a 16x baud tick; a load is held pending until the next tick
// so every bit boundary, including the start bit's, lines up with a tick.
module uart_transmitter
    import sram_uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       brclk16_tick,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic       UART_TX,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic                 pending_reg;
    logic                 active_reg;
    logic                 tx_reg;
    logic                 done_reg;
    logic [7:0]           byte_reg;
    logic [DATA_BITS:0]   shift_reg;
    logic [3:0]           bit_idx_reg;
    logic [TW-1:0]        tick_cnt_reg;

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            pending_reg  <= 1'b0;
            active_reg   <= 1'b0;
            tx_reg       <= STOP_BIT;
            done_reg     <= 1'b0;
            byte_reg     <= '0;
            shift_reg    <= '1;
            bit_idx_reg  <= '0;
            tick_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            if (tx_load && !pending_reg && !active_reg) begin
                pending_reg <= 1'b1;
                byte_reg    <= tx_byte;
            end
            if (pending_reg && brclk16_tick) begin
                pending_reg  <= 1'b0;
                active_reg   <= 1'b1;
                tx_reg       <= START_BIT;
                shift_reg    <= {STOP_BIT, byte_reg};
                bit_idx_reg  <= '0;
                tick_cnt_reg <= '0;
            end else if (active_reg && brclk16_tick) begin
                if (tick_cnt_reg == TW'(OVERSAMPLE - 1)) begin
                    tick_cnt_reg <= '0;
                    // Index DATA_BITS+1 is the stop bit; its last tick ends the frame.
                    if (bit_idx_reg == 4'(DATA_BITS + 1)) begin
                        active_reg <= 1'b0;
                        done_reg   <= 1'b1;
                        tx_reg     <= STOP_BIT;
                    end else begin
                        tx_reg      <= shift_reg[0];
                        shift_reg   <= {STOP_BIT, shift_reg[DATA_BITS:1]};
                        bit_idx_reg <= bit_idx_reg + 4'd1;
                    end
                end else begin
                    tick_cnt_reg <= tick_cnt_reg + TW'(1);
                end
            end
        end
    end

    assign UART_TX = tx_reg;
    assign tx_busy = pending_reg | active_reg;
    assign tx_done = done_reg;

endmodule

// File: rtl/sram_uart_dump.sv
// Reads word_count SRAM words from base_addr and sends each as two UART bytes, low byte first.
// Define SRAM_UART_DUMP_CHECKSUM_EN to append an XOR checksum byte after the last word.
module sram_uart_dump
    import sram_uart_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int READ_LAT   = 2,
    parameter int OVERSAMPLE = 16
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              brclk16_tick,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [15:0]       sram_rdata,
    output logic [ADDR_W-1:0] sram_addr_r,
    output logic              sram_rd_en,
    output logic              UART_TX,
    output logic              busy,
    output logic              done
);

    state_e            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] count_reg;
    logic [2:0]        wait_cnt_reg;
    logic [15:0]       rdata_reg;
    logic              tx_load_reg;
    logic [7:0]        tx_byte_mux;
    logic              tx_busy;
    logic              tx_done;
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
    logic [7:0]        chk_reg;
`endif

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            count_reg    <= '0;
            wait_cnt_reg <= '0;
            rdata_reg    <= '0;
            tx_load_reg  <= 1'b0;
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
            chk_reg      <= '0;
`endif
        end else begin
            tx_load_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
                        chk_reg <= '0;
`endif
                        if (word_count != '0) begin
                            addr_reg  <= base_addr;
                            count_reg <= word_count;
                            state_reg <= RD;
                        end else begin
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
                            tx_load_reg <= 1'b1;
                            state_reg   <= TX_CK;
`else
                            state_reg   <= FIN;
`endif
                        end
                    end
                end
                RD: begin
                    wait_cnt_reg <= 3'd1;
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    // sram_rdata is only looked at on the READ_LAT-th cycle after the strobe.
                    if (wait_cnt_reg == 3'(READ_LAT)) begin
                        rdata_reg   <= sram_rdata;
                        tx_load_reg <= 1'b1;
                        state_reg   <= TX_LO;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 3'd1;
                    end
                end
                TX_LO: begin
                    if (tx_done) begin
                        tx_load_reg <= 1'b1;
                        state_reg   <= TX_HI;
                    end
                end
                TX_HI: begin
                    if (tx_done) begin
                        state_reg <= NEXT;
                    end
                end
                NEXT: begin
                    count_reg <= count_reg - ADDR_W'(1);
                    addr_reg  <= addr_reg + ADDR_W'(1);
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
                    chk_reg   <= chk_reg ^ rdata_reg[7:0] ^ rdata_reg[15:8];
`endif
                    if (count_reg != ADDR_W'(1)) begin
                        state_reg <= RD;
                    end else begin
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
                        tx_load_reg <= 1'b1;
                        state_reg   <= TX_CK;
`else
                        state_reg   <= FIN;
`endif
                    end
                end
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
                TX_CK: begin
                    if (tx_done) begin
                        state_reg <= FIN;
                    end
                end
`endif
                FIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        tx_byte_mux = rdata_reg[7:0];
        if (state_reg == TX_HI) begin
            tx_byte_mux = rdata_reg[15:8];
        end
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
        if (state_reg == TX_CK) begin
            tx_byte_mux = chk_reg;
        end
`endif
    end

    uart_transmitter #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tx (
        .sysclk       (sysclk),
        .reset        (reset),
        .brclk16_tick (brclk16_tick),
        .tx_load      (tx_load_reg & ~tx_busy),
        .tx_byte      (tx_byte_mux),
        .UART_TX      (UART_TX),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    assign sram_addr_r = addr_reg;
    assign sram_rd_en  = (state_reg == RD);
    assign busy        = (state_reg != IDLE) && (state_reg != FIN);
    assign done        = (state_reg == FIN);

endmodule

// File: tb/tb_sram_uart_dump.sv
// Randomized bench for sram_uart_dump: SRAM latency model, tick-level UART decoder and a
// word-list reference model of the expected byte and read-address streams.
module tb_sram_uart_dump;

    localparam int AW    = 19;
    localparam int RL    = 3;
    localparam int LIMIT = 20000;

    logic          sysclk = 1'b0;
    logic          reset;
    logic          brclk16_tick = 1'b0;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] word_count;
    logic [15:0]   sram_rdata = 16'h0;
    logic [AW-1:0] sram_addr_r;
    logic          sram_rd_en;
    logic          UART_TX;
    logic          busy;
    logic          done;

    sram_uart_dump #(
        .ADDR_W     (AW),
        .READ_LAT   (RL),
        .OVERSAMPLE (16)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .brclk16_tick (brclk16_tick),
        .start        (start),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .sram_rdata   (sram_rdata),
        .sram_addr_r  (sram_addr_r),
        .sram_rd_en   (sram_rd_en),
        .UART_TX      (UART_TX),
        .busy         (busy),
        .done         (done)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0]   mem [logic [AW-1:0]];
    logic [7:0]    rx_q [$];
    logic [AW-1:0] rd_q [$];

    int            cyc = 0;
    int            rd_cyc = -100;
    logic [AW-1:0] rd_addr = '0;
    int            tick_gap = 0;
    logic          prev_rd = 1'b0;
    logic          prev_tx = 1'b1;
    logic          prev_tick = 1'b0;
    logic          prev_rst = 1'b0;
    int            done_cnt = 0;
    int            busy_at_done = 0;
    int            busy_seen = 0;
    int            edge_err = 0;
    int            rd_long = 0;
    int            frame_err = 0;
    logic          dec_active = 1'b0;
    int            dec_samp = 0;
    logic          dec_bit = 1'b0;
    logic [7:0]    dec_byte = 8'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h0BAD;
    endfunction

    // Tick generation, SRAM latency model and UART decoding, all on the falling edge.
    always @(negedge sysclk) begin
        int bi;
        cyc++;
        if (tick_gap == 0) begin
            brclk16_tick = 1'b1;
            tick_gap = $urandom_range(0, 2);
        end else begin
            brclk16_tick = 1'b0;
            tick_gap--;
        end
        if (sram_rd_en) begin
            rd_cyc  = cyc;
            rd_addr = sram_addr_r;
            rd_q.push_back(sram_addr_r);
            if (prev_rd) rd_long++;
        end
        sram_rdata = (cyc == rd_cyc + RL) ? mem_rd(rd_addr) : 16'($urandom);
        prev_rd = sram_rd_en;
        if (done) begin
            done_cnt++;
            if (busy) busy_at_done++;
        end
        if (busy) busy_seen = 1;
        if (reset && prev_rst && (UART_TX !== prev_tx) && !prev_tick) edge_err++;
        if (!reset) begin
            dec_active = 1'b0;
        end else if (brclk16_tick) begin
            if (!dec_active && !UART_TX) begin
                dec_active = 1'b1;
                dec_samp = 0;
            end
            if (dec_active) begin
                bi = dec_samp / 16;
                if (dec_samp % 16 == 0) begin
                    dec_bit = UART_TX;
                    if (bi >= 1 && bi <= 8) dec_byte[bi-1] = UART_TX;
                    if (bi == 9 && UART_TX !== 1'b1) frame_err++;
                end else if (UART_TX !== dec_bit) begin
                    frame_err++;
                end
                if (dec_samp == 159) begin
                    rx_q.push_back(dec_byte);
                    dec_active = 1'b0;
                end else begin
                    dec_samp++;
                end
            end
        end
        prev_tx   = UART_TX;
        prev_tick = brclk16_tick;
        prev_rst  = reset;
    end

    task automatic run_dump(input logic [AW-1:0] b, input logic [AW-1:0] n, input bit spur);
        logic [7:0]    exp_b [$];
        logic [AW-1:0] exp_a [$];
        logic [7:0]    ck;
        logic [AW-1:0] a;
        logic [15:0]   w;
        int            guard;
        int            exp_busy;
        ck = 8'h0;
        for (int i = 0; i < int'(n); i++) begin
            a = b + AW'(i);
            w = mem_rd(a);
            exp_a.push_back(a);
            exp_b.push_back(w[7:0]);
            exp_b.push_back(w[15:8]);
            ck = ck ^ w[7:0] ^ w[15:8];
        end
`ifdef SRAM_UART_DUMP_CHECKSUM_EN
        exp_b.push_back(ck);
        exp_busy = 1;
`else
        exp_busy = (n != 0) ? 1 : 0;
`endif
        rx_q.delete();
        rd_q.delete();
        done_cnt = 0; busy_at_done = 0; busy_seen = 0;
        edge_err = 0; rd_long = 0; frame_err = 0;
        @(posedge sysclk); #1;
        start = 1'b1; base_addr = b; word_count = n;
        @(posedge sysclk); #1;
        start = 1'b0; base_addr = AW'($urandom); word_count = AW'($urandom);
        guard = 0;
        while (done_cnt == 0 && guard < LIMIT) begin
            @(posedge sysclk); #1;
            guard++;
            if (spur && guard == 300) begin
                start = 1'b1; base_addr = b + AW'(100); word_count = AW'(5);
            end else begin
                start = 1'b0;
            end
        end
        check_eq("done_timeout", guard < LIMIT, 1);
`ifndef SRAM_UART_DUMP_CHECKSUM_EN
        if (n == 0) check_eq("zero_done_latency", guard <= 2, 1);
`endif
        repeat (400) @(posedge sysclk);
        #1;
        check_eq("done_pulses", done_cnt, 1);
        check_eq("busy_at_done", busy_at_done, 0);
        check_eq("busy_seen", busy_seen, exp_busy);
        check_eq("frame_format", frame_err, 0);
        check_eq("edge_off_tick", edge_err, 0);
        check_eq("rd_en_width", rd_long, 0);
        check_eq("line_idle_after", {dec_active, UART_TX}, 2'b01);
        check_eq("byte_count", rx_q.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++)
            check_eq("byte", rx_q[i], exp_b[i]);
        check_eq("read_count", rd_q.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < rd_q.size(); i++)
            check_eq("read_addr", rd_q[i], exp_a[i]);
        $display("dump base=0x%05h count=%0d bytes=%0d reads=%0d done=%0d",
                 b, n, rx_q.size(), rd_q.size(), done_cnt);
    endtask

    initial begin
        int guard;
        logic [AW-1:0] b;
        logic [AW-1:0] n;
        reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        repeat (5) @(posedge sysclk);
        #1;
        check_eq("rst_uart_tx", UART_TX, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rd_en", sram_rd_en, 0);
        check_eq("rst_addr", sram_addr_r, 0);
        reset = 1'b1;

        mem[19'h00010] = 16'hA55A;
        run_dump(19'h00010, 19'd1, 1'b0);
        run_dump(19'h00123, 19'd0, 1'b0);
        mem[19'h7FFFF] = 16'h1234;
        mem[19'h00000] = 16'hBEEF;
        run_dump(19'h7FFFF, 19'd2, 1'b0);

        // Reset lands inside the 4th data bit of the first byte.
        mem[19'h00020] = 16'h3C96;
        rx_q.delete();
        done_cnt = 0;
        @(posedge sysclk); #1;
        start = 1'b1; base_addr = 19'h00020; word_count = 19'd1;
        @(posedge sysclk); #1;
        start = 1'b0;
        guard = 0;
        while (!(dec_active && dec_samp >= 66) && guard < LIMIT) begin
            @(posedge sysclk); #1;
            guard++;
        end
        check_eq("midreset_reach", guard < LIMIT, 1);
        reset = 1'b0;
        @(posedge sysclk); #1;
        check_eq("midreset_uart_tx", UART_TX, 1);
        check_eq("midreset_busy", busy, 0);
        check_eq("midreset_rd_en", sram_rd_en, 0);
        repeat (4) @(posedge sysclk);
        #1;
        reset = 1'b1;
        repeat (200) @(posedge sysclk);
        #1;
        check_eq("midreset_no_done", done_cnt, 0);
        check_eq("midreset_no_byte", rx_q.size(), 0);
        $display("mid-frame reset applied at sample %0d", dec_samp);
        run_dump(19'h00020, 19'd1, 1'b0);

        for (int i = 0; i < 3; i++) mem[19'h00400 + 19'(i)] = 16'($urandom);
        run_dump(19'h00400, 19'd3, 1'b1);

        for (int t = 0; t < 5; t++) begin
            b = (t % 2 == 0) ? AW'($urandom) : 19'h7FFFF - AW'($urandom_range(0, 2));
            n = AW'($urandom_range(1, 4));
            for (int i = 0; i < int'(n); i++) mem[b + AW'(i)] = 16'($urandom);
            run_dump(b, n, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
